// File: rtl/udiv_pkg.sv
// udiv_pkg: shared state encoding and counter sizing
// for the sequential unsigned divider.
package udiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/udiv_seq_core_step.sv
// udiv_step: one restoring-division iteration,
// shift in the next dividend bit and trial-subtract.
module udiv_step #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shl;
  logic [WIDTH:0] dx;

  assign shl = {rem_in[WIDTH-1:0], q_msb};
  assign dx  = {1'b0, d};

  always_comb begin
    q_bit   = 1'b0;
    rem_out = shl;
    if (shl >= dx) begin
      q_bit   = 1'b1;
      rem_out = shl - dx;
    end
  end

endmodule

// File: rtl/udiv_seq_core.sv
// udiv_seq_core: iterative restoring unsigned divider.
// Option macro: UDIV_SEQ_EARLY_OUT_EN (a<b finishes on accept).
module udiv_seq_core
  import udiv_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             dbz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = cnt_w(WIDTH);

  state_t         state;
  state_t         state_d;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] r_q;
  logic [WIDTH:0] r_nx;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d_q;
  logic           q_bit;
  logic           accept;
  logic           last;
  logic           b_zero;
  logic           early;

  udiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (r_q),
    .q_msb  (q_sh[WIDTH-1]),
    .d      (d_q),
    .rem_out(r_nx),
    .q_bit  (q_bit)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign b_zero = (b == '0);

`ifdef UDIV_SEQ_EARLY_OUT_EN
  assign early = (a < b);
`else
  assign early = 1'b0;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    unique case (1'b1)
      (state == RUN): begin
        if (last) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        if (enable) begin
          accept  = 1'b1;
          state_d = (b_zero || early) ? DONE : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      r_q      <= '0;
      q_sh     <= '0;
      d_q      <= '0;
      valid    <= 1'b0;
      dbz      <= 1'b0;
      quotient <= '0;
      rem      <= '0;
    end else if (accept) begin
      cnt   <= '0;
      r_q   <= '0;
      q_sh  <= a;
      d_q   <= b;
      valid <= 1'b0;
      dbz   <= 1'b0;
      if (b_zero) begin
        dbz      <= 1'b1;
        quotient <= '1;
        rem      <= a;
      end else if (early) begin
        valid    <= 1'b1;
        quotient <= '0;
        rem      <= a;
      end
    end else if (state == RUN) begin
      cnt  <= cnt + CW'(1);
      r_q  <= r_nx;
      q_sh <= {q_sh[WIDTH-2:0], q_bit};
      // partial remainder is one bit wider; result drops the guard bit
      if (last) begin
        valid    <= 1'b1;
        quotient <= {q_sh[WIDTH-2:0], q_bit};
        rem      <= r_nx[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_udiv_seq_core.sv
// tb_udiv_seq_core: scoreboard bench for udiv_seq_core,
// WIDTH=10; honours UDIV_SEQ_EARLY_OUT_EN when defined.
module tb_udiv_seq_core;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         valid;
  logic         dbz;
  logic [W-1:0] quotient;
  logic [W-1:0] rem;

  int checks = 0;
  int errors = 0;
  int both_hi = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         v;
    logic         z;
    int           lat;
  } exp_t;

  exp_t sb[$];

  udiv_seq_core #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .valid   (valid),
    .dbz     (dbz),
    .quotient(quotient),
    .rem     (rem)
  );

  always #5 clk = ~clk;

  // lat = rising edges from the accept edge (inclusive) to done
  function automatic exp_t model(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    exp_t e;
    if (y == '0) begin
      e.q = '1;
      e.r = x;
      e.v = 1'b0;
      e.z = 1'b1;
      e.lat = 1;
    end else begin
      e.q = x / y;
      e.r = x % y;
      e.v = 1'b1;
      e.z = 1'b0;
      e.lat = W + 1;
`ifdef UDIV_SEQ_EARLY_OUT_EN
      if (x < y) e.lat = 1;
`endif
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (valid && dbz) both_hi++;
  endtask

  task automatic drive(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    enable = 1'b1;
    a = x;
    b = y;
    sb.push_back(model(x, y));
  endtask

  task automatic wait_done(
    input  bit drop,
    output int lat,
    output int bcnt,
    output bit to
  );
    lat = 0;
    bcnt = 0;
    to = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (drop) enable = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        to = 1'b0;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({busy, done, valid, dbz, quotient, rem} !== '0) begin
      errors++;
      $display("FAIL reset: b%b d%b v%b z%b q%0d r%0d want all 0",
               busy, done, valid, dbz, quotient, rem);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_normal();
    int lat, bc;
    bit to;
    exp_t e;
    drive(10'd100, 10'd7);
    wait_done(1'b1, lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat) begin
      errors++;
      $display("FAIL normal_lat: got %0d to=%0d want %0d", lat, to, e.lat);
    end
    checks++;
    if (bc !== W) begin
      errors++;
      $display("FAIL normal_busy: got %0d want %0d", bc, W);
    end
    checks++;
    if (quotient !== e.q || rem !== e.r || valid !== e.v || dbz !== e.z) begin
      errors++;
      $display("FAIL normal_res: q%0d r%0d v%b z%b want q%0d r%0d v%b z%b",
               quotient, rem, valid, dbz, e.q, e.r, e.v, e.z);
    end
    step();
    checks++;
    if (done !== 1'b0 || valid !== 1'b1 || quotient !== e.q) begin
      errors++;
      $display("FAIL normal_hold: d%b v%b q%0d want d0 v1 q%0d",
               done, valid, quotient, e.q);
    end
  endtask

  task automatic test_dbz();
    int lat, bc;
    bit to;
    exp_t e;
    drive(10'd5, 10'd0);
    wait_done(1'b1, lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || bc !== 0) begin
      errors++;
      $display("FAIL dbz_lat: lat %0d busy %0d want %0d/0", lat, bc, e.lat);
    end
    checks++;
    if (quotient !== e.q || rem !== e.r || valid !== e.v || dbz !== e.z) begin
      errors++;
      $display("FAIL dbz_res: q%0d r%0d v%b z%b want q%0d r%0d v%b z%b",
               quotient, rem, valid, dbz, e.q, e.r, e.v, e.z);
    end
    step();
    checks++;
    if (done !== 1'b0 || dbz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_hold: d%b z%b want d0 z1", done, dbz);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit to;
    exp_t e;
    drive(10'd1023, 10'd1);
    wait_done(1'b0, lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || quotient !== e.q || rem !== e.r) begin
      errors++;
      $display("FAIL b2b_first: lat %0d q%0d r%0d want %0d q%0d r%0d",
               lat, quotient, rem, e.lat, e.q, e.r);
    end
    drive(10'd1000, 10'd1000);
    wait_done(1'b1, lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || bc !== W) begin
      errors++;
      $display("FAIL b2b_lat: lat %0d busy %0d want %0d/%0d",
               lat, bc, e.lat, W);
    end
    checks++;
    if (quotient !== e.q || rem !== e.r || valid !== e.v) begin
      errors++;
      $display("FAIL b2b_res: q%0d r%0d v%b want q%0d r%0d v%b",
               quotient, rem, valid, e.q, e.r, e.v);
    end
    step();
  endtask

  task automatic test_busy_ignore();
    int lat, bc;
    bit to;
    exp_t e;
    drive(10'd100, 10'd7);
    step();
    for (int i = 0; i < 5; i++) begin
      enable = ~enable;
      a = W'($urandom);
      b = '0;
      step();
    end
    enable = 1'b0;
    wait_done(1'b1, lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || (lat + 6) !== e.lat) begin
      errors++;
      $display("FAIL ignore_lat: got %0d want %0d", lat + 6, e.lat);
    end
    checks++;
    if (quotient !== e.q || rem !== e.r || valid !== 1'b1 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL ignore_res: q%0d r%0d v%b z%b want q%0d r%0d v1 z0",
               quotient, rem, valid, dbz, e.q, e.r);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, bc, dn;
    bit to;
    exp_t e;
    drive(10'd100, 10'd7);
    step();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    checks++;
    if ({busy, done, valid, dbz, quotient, rem} !== '0) begin
      errors++;
      $display("FAIL rst_mid: b%b d%b v%b z%b q%0d r%0d want all 0",
               busy, done, valid, dbz, quotient, rem);
    end
    step();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL rst_nodone: got %0d active cycles want 0", dn);
    end
    drive(10'd100, 10'd7);
    wait_done(1'b1, lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || quotient !== e.q || rem !== e.r) begin
      errors++;
      $display("FAIL rst_next: lat %0d q%0d r%0d want %0d q%0d r%0d",
               lat, quotient, rem, e.lat, e.q, e.r);
    end
    step();
  endtask

  task automatic test_small();
    int lat, bc;
    bit to;
    exp_t e;
    drive(10'd3, 10'd9);
    wait_done(1'b1, lat, bc, to);
    e = sb.pop_front();
    checks++;
    if (to || lat !== e.lat || bc !== ((e.lat == 1) ? 0 : W)) begin
      errors++;
      $display("FAIL small_lat: lat %0d busy %0d want %0d", lat, bc, e.lat);
    end
    checks++;
    if (quotient !== e.q || rem !== e.r || valid !== 1'b1 || dbz !== 1'b0) begin
      errors++;
      $display("FAIL small_res: q%0d r%0d v%b z%b want q%0d r%0d v1 z0",
               quotient, rem, valid, dbz, e.q, e.r);
    end
    step();
  endtask

  task automatic test_random();
    int lat, bc;
    bit to;
    exp_t e;
    logic [W-1:0] x, y;
    for (int n = 0; n < 8; n++) begin
      x = W'($urandom);
      y = W'($urandom_range(0, 60));
      drive(x, y);
      wait_done(1'b1, lat, bc, to);
      e = sb.pop_front();
      checks++;
      if (to || lat !== e.lat || quotient !== e.q || rem !== e.r ||
          valid !== e.v || dbz !== e.z) begin
        errors++;
        $display("FAIL rand %0d/%0d: lat %0d q%0d r%0d v%b z%b want %0d q%0d r%0d v%b z%b",
                 x, y, lat, quotient, rem, valid, dbz,
                 e.lat, e.q, e.r, e.v, e.z);
      end
      step();
    end
    checks++;
    if (both_hi !== 0) begin
      errors++;
      $display("FAIL valid_dbz_excl: got %0d cycles want 0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_dbz();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_small();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
